// File: rtl/p3_run_ctrl.sv
// rtl/p3_run_ctrl.sv - run controller: loads operands, launches the core, reads back and reports the product
//
// Ports:
//   clk_i, reset_i                 single clock, synchronous active-high reset
//   op_valid_i/op_ready_o          operand triple handshake, op_a_i/op_b_i/op_c_i signed bytes
//   dm_addr_o, dm_wr_en_o,         data memory port; dm_rd_data_i is combinational
//   dm_wr_data_o, dm_rd_data_i       on dm_addr_o
//   core_reset_o, core_start_o     core control; a falling edge on core_start_o launches the program
//   core_done_i                    core completion flag
//   res_valid_o/res_ready_i        result handshake; res_prod_o, res_expect_o, res_match_o,
//                                  res_timeout_o read as zero unless res_valid_o is high
module p3_run_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  OP_BASE        = 8'd0,
  parameter logic [7:0]  PROD_BASE      = 8'd4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic [7:0]  op_a_i,
  input  logic [7:0]  op_b_i,
  input  logic [7:0]  op_c_i,
  output logic [7:0]  dm_addr_o,
  output logic        dm_wr_en_o,
  output logic [7:0]  dm_wr_data_o,
  input  logic [7:0]  dm_rd_data_i,
  output logic        core_reset_o,
  output logic        core_start_o,
  input  logic        core_done_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [23:0] res_prod_o,
  output logic [23:0] res_expect_o,
  output logic        res_match_o,
  output logic        res_timeout_o
);
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD0, S_LOAD1, S_LOAD2, S_ARM, S_LAUNCH,
    S_WAIT, S_RD0, S_RD1, S_RD2, S_REPORT
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         a_q, a_d, b_q, b_d, c_q, c_d;
  logic [23:0]        prod_q, prod_d;
  logic               timeout_q, timeout_d;
  logic               seen_low_q, seen_low_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [23:0] a_ext, b_ext, c_ext;
  logic [23:0]        expect_w;
  logic               report;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      prod_q     <= '0;
      timeout_q  <= 1'b0;
      seen_low_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      prod_q     <= prod_d;
      timeout_q  <= timeout_d;
      seen_low_q <= seen_low_d;
      cnt_q      <= cnt_d;
    end
  end

  // Truncation to 24 bits is exact: |A*B*C| <= 2^21.
  assign a_ext    = {{16{a_q[7]}}, a_q};
  assign b_ext    = {{16{b_q[7]}}, b_q};
  assign c_ext    = {{16{c_q[7]}}, c_q};
  assign expect_w = a_ext * b_ext * c_ext;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    c_d          = c_q;
    prod_d       = prod_q;
    timeout_d    = timeout_q;
    seen_low_d   = seen_low_q;
    cnt_d        = cnt_q;
    op_ready_o   = 1'b0;
    dm_addr_o    = '0;
    dm_wr_en_o   = 1'b0;
    dm_wr_data_o = '0;
    core_reset_o = 1'b0;
    core_start_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        op_ready_o   = 1'b1;
        core_reset_o = 1'b1;
        core_start_o = 1'b1;
        if (op_valid_i) begin
          a_d       = op_a_i;
          b_d       = op_b_i;
          c_d       = op_c_i;
          prod_d    = '0;
          timeout_d = 1'b0;
          state_d   = S_LOAD0;
        end
      end
      S_LOAD0: begin
        dm_wr_en_o   = 1'b1;
        dm_addr_o    = OP_BASE;
        dm_wr_data_o = a_q;
        core_reset_o = 1'b1;
        core_start_o = 1'b1;
        state_d      = S_LOAD1;
      end
      S_LOAD1: begin
        dm_wr_en_o   = 1'b1;
        dm_addr_o    = OP_BASE + 8'd1;
        dm_wr_data_o = b_q;
        core_reset_o = 1'b1;
        core_start_o = 1'b1;
        state_d      = S_LOAD2;
      end
      S_LOAD2: begin
        dm_wr_en_o   = 1'b1;
        dm_addr_o    = OP_BASE + 8'd2;
        dm_wr_data_o = c_q;
        core_reset_o = 1'b1;
        core_start_o = 1'b1;
        state_d      = S_ARM;
      end
      S_ARM: begin
        core_start_o = 1'b1;
        state_d      = S_LAUNCH;
      end
      S_LAUNCH: begin
        cnt_d      = '0;
        seen_low_d = 1'b0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        cnt_d      = cnt_q + CNT_W'(1);
        // A done left high from a previous run must be seen low once before it counts.
        seen_low_d = seen_low_q | ~core_done_i;
        if (seen_low_q && core_done_i) begin
          state_d = S_RD0;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          prod_d    = '0;
          state_d   = S_REPORT;
        end
      end
      S_RD0: begin
        dm_addr_o      = PROD_BASE;
        prod_d[23:16]  = dm_rd_data_i;
        state_d        = S_RD1;
      end
      S_RD1: begin
        dm_addr_o      = PROD_BASE + 8'd1;
        prod_d[15:8]   = dm_rd_data_i;
        state_d        = S_RD2;
      end
      S_RD2: begin
        dm_addr_o      = PROD_BASE + 8'd2;
        prod_d[7:0]    = dm_rd_data_i;
        state_d        = S_REPORT;
      end
      S_REPORT: begin
        // Core goes back into reset in the same cycle the result is taken.
        if (res_ready_i) begin
          core_reset_o = 1'b1;
          core_start_o = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign report        = (state_q == S_REPORT);
  assign res_valid_o   = report;
  assign res_prod_o    = report ? prod_q : '0;
  assign res_expect_o  = report ? expect_w : '0;
  assign res_timeout_o = report & timeout_q;
  assign res_match_o   = report & ~timeout_q & (prod_q == expect_w);

endmodule

// File: tb/tb_p3_run_ctrl.sv
// tb/tb_p3_run_ctrl.sv - randomized self-checking bench for p3_run_ctrl with a behavioural core model
module tb_p3_run_ctrl;
  localparam int         TMO = 16;
  localparam logic [7:0] PB  = 8'd4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, op_valid, op_ready;
  logic [7:0]  op_a, op_b, op_c;
  logic [7:0]  dm_addr, dm_wr_data, dm_rd_data;
  logic        dm_wr_en;
  logic        core_reset, core_start, core_done;
  logic        res_valid, res_ready;
  logic [23:0] res_prod, res_expect;
  logic        res_match, res_timeout;

  logic [7:0] mem [256];
  assign dm_rd_data = mem[dm_addr];

  p3_run_ctrl #(.TIMEOUT_CYCLES(TMO), .OP_BASE(8'd0), .PROD_BASE(PB)) dut (
    .clk_i(clk), .reset_i(reset),
    .op_valid_i(op_valid), .op_ready_o(op_ready),
    .op_a_i(op_a), .op_b_i(op_b), .op_c_i(op_c),
    .dm_addr_o(dm_addr), .dm_wr_en_o(dm_wr_en), .dm_wr_data_o(dm_wr_data), .dm_rd_data_i(dm_rd_data),
    .core_reset_o(core_reset), .core_start_o(core_start), .core_done_i(core_done),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_prod_o(res_prod), .res_expect_o(res_expect),
    .res_match_o(res_match), .res_timeout_o(res_timeout)
  );

  int checks = 0, failures = 0, cyc = 0;
  // core model: mode 0 normal, 1 stale done, 2 hang, 3 corrupt product byte
  int   mode = 0, delay = 1, ccnt = 0;
  bit   running = 0, core_fin = 0;
  logic prev_start = 1'b1;
  int   launch_cyc = 0, done_cyc = 0, rd_early = 0;
  int         wr_cyc[$];
  logic [7:0] wr_addr[$], wr_data[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic tick();
    logic [23:0] p;
    @(negedge clk);
    cyc++;
    if (dm_wr_en) begin
      mem[dm_addr] = dm_wr_data;
      wr_cyc.push_back(cyc);
      wr_addr.push_back(dm_addr);
      wr_data.push_back(dm_wr_data);
    end
    if (!dm_wr_en && dm_addr >= PB && dm_addr <= PB + 8'd2 && !core_fin) rd_early++;
    if (core_reset) begin
      running   = 0;
      core_done = (mode == 1);
    end else if (prev_start && !core_start) begin
      launch_cyc = cyc;
      running    = (mode != 2);
      ccnt       = delay;
      core_fin   = 0;
    end else if (running) begin
      if (ccnt == 0) begin
        p = 24'(sx8(mem[0]) * sx8(mem[1]) * sx8(mem[2]));
        mem[PB]        = p[23:16];
        mem[PB + 8'd1] = p[15:8];
        mem[PB + 8'd2] = (mode == 3) ? (p[7:0] ^ 8'h5A) : p[7:0];
        core_done = 1'b1;
        done_cyc  = cyc;
        running   = 0;
        core_fin  = 1;
      end else begin
        if (mode == 1 && ccnt == 2) core_done = 1'b0;
        ccnt--;
      end
    end
    prev_start = core_start;
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input int md, input int stall);
    int          n, acc, t_valid;
    logic [23:0] e_val, e_prod;
    logic [7:0]  ops [3];
    bit          e_to;
    mode   = md;
    delay  = (md == 1) ? 6 : int'($urandom_range(8, 1));
    ops[0] = a; ops[1] = b; ops[2] = c;
    e_val  = 24'(sx8(a) * sx8(b) * sx8(c));
    e_to   = (md == 2);
    e_prod = e_to ? 24'h0 : ((md == 3) ? (e_val ^ 24'h00005A) : e_val);

    n = 0;
    while (!op_ready && n < 100) begin tick(); n++; end
    chk($sformatf("%s.op_ready", tag), 32'(op_ready), 1);
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    rd_early = 0;
    op_a = a; op_b = b; op_c = c; op_valid = 1'b1; acc = cyc;
    tick();
    op_valid = 1'b0;
    op_a = 8'($urandom); op_b = 8'($urandom); op_c = 8'($urandom);

    n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    t_valid = cyc;
    chk($sformatf("%s.res_valid", tag), 32'(res_valid), 1);

    chk($sformatf("%s.nwrites", tag), wr_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_cyc.size()) begin
        chk($sformatf("%s.wr%0d_addr", tag, i), 32'(wr_addr[i]), i);
        chk($sformatf("%s.wr%0d_data", tag, i), 32'(wr_data[i]), 32'(ops[i]));
        chk($sformatf("%s.wr%0d_cyc", tag, i), wr_cyc[i] - acc, i + 1);
      end
    end
    chk($sformatf("%s.launch_lat", tag), launch_cyc - acc, 5);
    if (e_to) chk($sformatf("%s.timeout_lat", tag), t_valid - launch_cyc, TMO + 1);
    else      chk($sformatf("%s.done_lat", tag), t_valid - done_cyc, 4);
    chk($sformatf("%s.rd_early", tag), rd_early, 0);
    chk($sformatf("%s.prod", tag), 32'(res_prod), 32'(e_prod));
    chk($sformatf("%s.expect", tag), 32'(res_expect), 32'(e_val));
    chk($sformatf("%s.match", tag), 32'(res_match), 32'(!e_to && e_prod == e_val));
    chk($sformatf("%s.timeout", tag), 32'(res_timeout), 32'(e_to));
    chk($sformatf("%s.busy_ready", tag), 32'(op_ready), 0);

    op_valid = (stall > 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk($sformatf("%s.stall_valid", tag), 32'(res_valid), 1);
      chk($sformatf("%s.stall_prod", tag), 32'(res_prod), 32'(e_prod));
      chk($sformatf("%s.stall_ready", tag), 32'(op_ready), 0);
    end
    op_valid = 1'b0;

    res_ready = 1'b1;
    #1;
    chk($sformatf("%s.rel_core_reset", tag), 32'(core_reset), 1);
    chk($sformatf("%s.rel_core_start", tag), 32'(core_start), 1);
    tick();
    res_ready = 1'b0;
    chk($sformatf("%s.idle_valid", tag), 32'(res_valid), 0);
    chk($sformatf("%s.idle_ready", tag), 32'(op_ready), 1);
    chk($sformatf("%s.idle_core_reset", tag), 32'(core_reset), 1);
    chk($sformatf("%s.no_extra_wr", tag), wr_cyc.size(), 3);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1; op_valid = 1'b0; res_ready = 1'b0; core_done = 1'b0;
    op_a = 8'h0; op_b = 8'h0; op_c = 8'h0;
    repeat (3) tick();
    chk("rst.op_ready", 32'(op_ready), 1);
    chk("rst.core_reset", 32'(core_reset), 1);
    chk("rst.core_start", 32'(core_start), 1);
    chk("rst.dm_wr_en", 32'(dm_wr_en), 0);
    chk("rst.dm_addr", 32'(dm_addr), 0);
    chk("rst.dm_wr_data", 32'(dm_wr_data), 0);
    chk("rst.res_valid", 32'(res_valid), 0);
    chk("rst.res_prod", 32'(res_prod), 0);
    chk("rst.res_expect", 32'(res_expect), 0);
    chk("rst.res_match", 32'(res_match), 0);
    chk("rst.res_timeout", 32'(res_timeout), 0);
    reset = 1'b0;
    tick();

    run_op("basic",   8'd2,   8'd3,   8'd4,   0, 0);
    run_op("neg",     8'hFE,  8'hEC,  8'h04,  0, 0);
    run_op("big",     8'd32,  8'd32,  8'hE0,  0, 1);
    run_op("min",     8'h80,  8'h80,  8'h80,  0, 0);
    run_op("corrupt", 8'd5,   8'd7,   8'd9,   3, 0);

    mode = 1; reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    run_op("stale",   8'd6,   8'hF9,  8'd3,   1, 0);
    run_op("hang",    8'd3,   8'd5,   8'd7,   2, 0);
    run_op("stall",   8'd11,  8'hFD,  8'd6,   0, 10);

    // abort a run mid-WAIT with a reset pulse
    mode = 2;
    op_a = 8'd9; op_b = 8'd9; op_c = 8'd9; op_valid = 1'b1;
    tick();
    op_valid = 1'b0;
    launch_cyc = -1;
    n = 0;
    while (launch_cyc < 0 && n < 50) begin tick(); n++; end
    chk("abort.launch_seen", 32'(launch_cyc >= 0), 1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort.res_valid", 32'(res_valid), 0);
    chk("abort.core_reset", 32'(core_reset), 1);
    chk("abort.core_start", 32'(core_start), 1);
    chk("abort.op_ready", 32'(op_ready), 1);
    run_op("after_abort", 8'hF0, 8'd10, 8'hFB, 0, 0);

    for (int k = 0; k < 10; k++) begin
      run_op($sformatf("rnd%0d", k), 8'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(3, 0) == 0) ? 3 : 0, int'($urandom_range(3, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/p3_run_ctrl.md
# p3_run_ctrl

Hardware run controller that sits directly upstream and downstream of the program-3 processor core (`top_level`). It accepts an operand triple (A, B, C), writes the operands into the core's data memory at addresses 0..2, and initiates the run with a falling edge on `start`. It then waits for `done`, reads the big-endian 24-bit product from addresses 4..6, and reports that product alongside a locally computed expected value. It replaces the behavioural bench sequencing, so regression runs can be back-to-back and synthesizable.

## Interface
- `TIMEOUT_CYCLES`, 4096: maximum number of WAIT cycles before the run is aborted.
- `OP_BASE`, 0: data memory address of OpA. OpB and OpC follow at +1 and +2.
- `PROD_BASE`, 4: data memory address of the product MSB. Bytes at +1 and +2 follow.
- `clk` in 1: single clock for the block and the core.
- `reset` in 1: synchronous, active-high reset.
- `op_valid` in 1: an operand triple is offered.
- `op_ready` out 1: the block can accept a triple.
- `op_a`, `op_b`, `op_c` in 8 each: signed two's-complement operands.
- `dm_addr` out 8: data memory address.
- `dm_wr_en` out 1: data memory write strobe.
- `dm_wr_data` out 8: data memory write byte.
- `dm_rd_data` in 8: data memory read byte. Combinational: valid in the same cycle as `dm_addr`.
- `core_reset` out 1: reset to the core (PC = 0 while high).
- `core_start` out 1: start to the core. A falling edge initiates the program.
- `core_done` in 1: core completion flag.
- `res_valid` out 1: a result is held.
- `res_ready` in 1: the consumer accepts the result.
- `res_prod` out 24: signed product assembled from memory.
- `res_expect` out 24: signed A*B*C computed locally.
- `res_match` out 1: `res_prod == res_expect`.
- `res_timeout` out 1: the run was aborted by timeout.

## Operation
- State sequence: IDLE → LOAD0 → LOAD1 → LOAD2 → ARM → LAUNCH → WAIT → RD0 → RD1 → RD2 → REPORT → IDLE.
- **IDLE**
  - `op_ready`=1.
  - On `op_valid`&`op_ready`, register A, B and C, then go to LOAD0.
- **LOADn**
  - `dm_wr_en`=1, `dm_addr`=`OP_BASE`+n.
  - `dm_wr_data` is A, B or C for n = 0, 1, 2 respectively.
  - `core_reset` and `core_start` are held at 1.
- **ARM**
  - `core_reset`=0, `core_start`=1 for exactly one cycle.
- **LAUNCH**
  - `core_start`=0 for one cycle.
  - The wait counter and the seen-low flag are cleared.
  - Go to WAIT.
- **WAIT**
  - `core_start` stays 0 and the counter increments every cycle.
  - Stale-done guard: `core_done` is honoured only after it has been sampled 0 at least once since LAUNCH.
  - When a guarded `core_done`=1 is seen, go to RD0.
  - If the counter reaches `TIMEOUT_CYCLES`, go to REPORT with `res_timeout`=1 and `res_prod`=0.
  - Done and timeout in the same cycle: done wins.
- **RDn**
  - `dm_addr`=`PROD_BASE`+n and `dm_wr_en`=0.
  - Capture `dm_rd_data` into product byte 2-n. RD0 supplies bits [23:16] (big-endian).
  - `core_start` stays 0 so the core is not re-triggered.
- **REPORT**
  - `res_valid`=1 and all `res_*` outputs are stable.
  - On `res_ready`, go to IDLE. In the same cycle the block sets `core_start`=1 and `core_reset`=1.
- Expected-value arithmetic:
  - Each operand is sign-extended, then multiplied as A*B*C.
  - The result is truncated to 24 bits. This is exact: the magnitude is at most 2^21.
  - Compute it combinationally from the registered operands, or over several cycles, provided it is complete before REPORT.
- `res_match` is 0 whenever `res_timeout`=1.

## Timing
- Reset values:
  - State = IDLE.
  - `op_ready`=1, `core_reset`=1, `core_start`=1.
  - `dm_wr_en`=0, `dm_addr`=0, `dm_wr_data`=0.
  - `res_valid`=0 and every `res_*` output = 0.
- Asserting `reset` in any state, including WAIT or REPORT, aborts the run on the next edge:
  - No result is emitted.
  - `core_reset` returns to 1.
  - Partial memory writes are not undone.
- Latency:
  - Accept edge to first write: 1 cycle.
  - Writes occupy 3 cycles. ARM is 1 cycle and LAUNCH is 1 cycle.
  - The `core_start` falling edge occurs 5 cycles after the accept edge.
  - From guarded done to `res_valid`: 4 cycles (RD0..RD2, then REPORT).
- `op_ready` is 0 outside IDLE. A triple offered while busy is not consumed.
- `res_valid` is held until `res_ready`. All result fields are frozen while stalled.
- Minimum accept-to-accept time is 12 cycles plus the core run time.

## Test plan
- A=2, B=3, C=4; core writes 00,00,18 → `res_prod`=`res_expect`=0x000018, `res_match`=1.
- A=-2, B=-20, C=4 → expect 0x0000A0. Check dm writes FE, EC, 04 land at addresses 0..2 in consecutive cycles.
- A=32, B=32, C=-32 → 0xFF8000. A=-128, B=-128, C=-128 → 0xE00000, both with `res_match`=1. Then corrupt mem[6] → `res_match`=0.
- Hold `core_done`=1 from reset onward → no read until done drops and rises again. Never drop it with `TIMEOUT_CYCLES`=16 → `res_timeout`=1, `res_prod`=0, `res_match`=0 after 16 WAIT cycles.
- Hold `res_ready`=0 for 10 cycles in REPORT → outputs stable, `op_ready`=0, a second `op_valid` is ignored. Release → IDLE, `core_reset`=1.
- Pulse `reset` during WAIT → next cycle IDLE, `res_valid`=0, `core_reset`=1, `core_start`=1. A subsequent triple completes normally.
